mult_share_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the single shared 8x8 multiplier in the RGBW lamp datapath. Up to four requesters (red, green, blue, white intensity-scaling paths of the colour generator) post operand pairs; the block grants one at a time, drives the multiplier load strobe, waits for its ready flag, and returns the 16-bit product with a per-requester done pulse. A watchdog aborts a multiply that never completes. Runs on the prescaled system clock, alongside the PWM and colour logic.

---
 rtl/mult_share_arbiter.sv | 145 ++++++++++++++
 tb/tb_mult_share_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one 8x8 multiplier among N_REQ requesters,
// with a watchdog that aborts a multiply whose ready flag never arrives.
module mult_share_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   op_a,
    input  logic [8*N_REQ-1:0]   op_b,
    output logic [N_REQ-1:0]     gnt,
    output logic [N_REQ-1:0]     done,
    output logic                 err,
    output logic [15:0]          result,
    output logic                 mult_ld,
    output logic [7:0]           mult_a,
    output logic [7:0]           mult_b,
    input  logic                 mult_rdy,
    input  logic [15:0]          mult_result
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic               err_q, err_d;
    logic [15:0]        result_q, result_d;
    logic               mult_ld_q, mult_ld_d;
    logic [7:0]         mult_a_q, mult_a_d;
    logic [7:0]         mult_b_q, mult_b_d;

    logic [PW-1:0]      sel;
    logic               any_req;

    // Scan starts one past the last winner so the previous grantee is checked last.
    always_comb begin
        int unsigned cand;
        logic [PW-1:0] c_idx;
        sel     = ptr_q;
        any_req = 1'b0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand  = (32'(ptr_q) + k) % N_REQ;
            c_idx = PW'(cand);
            if (!any_req && req[c_idx]) begin
                sel     = c_idx;
                any_req = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        done_d    = '0;
        err_d     = 1'b0;
        result_d  = result_q;
        mult_ld_d = 1'b0;
        mult_a_d  = mult_a_q;
        mult_b_d  = mult_b_q;
        unique case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    gnt_d     = N_REQ'(1) << sel;
                    mult_a_d  = op_a[8*sel +: 8];
                    mult_b_d  = op_b[8*sel +: 8];
                    ptr_d     = sel;
                    mult_ld_d = 1'b1;
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // Ready takes priority over the watchdog when both land on the same edge.
                if (mult_rdy) begin
                    result_d = mult_result;
                    done_d   = gnt_q;
                    state_d  = S_DONE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    done_d   = gnt_q;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                gnt_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            ptr_q     <= PW'(N_REQ - 1);
            cnt_q     <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            err_q     <= 1'b0;
            result_q  <= '0;
            mult_ld_q <= 1'b0;
            mult_a_q  <= '0;
            mult_b_q  <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            err_q     <= err_d;
            result_q  <= result_d;
            mult_ld_q <= mult_ld_d;
            mult_a_q  <= mult_a_d;
            mult_b_q  <= mult_b_d;
        end
    end

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign err     = err_q;
    assign result  = result_q;
    assign mult_ld = mult_ld_q;
    assign mult_a  = mult_a_q;
    assign mult_b  = mult_b_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Scoreboard bench for mult_share_arbiter: randomized requesters, a latency-programmable
// multiplier model, and a monitor checking grants, timing and results against a reference.
`timescale 1ns/1ps
module tb_mult_share_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned TO = 64;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     req;
    logic [8*N-1:0]   op_a, op_b;
    logic [N-1:0]     gnt, done;
    logic             err;
    logic [15:0]      result;
    logic             mult_ld;
    logic [7:0]       mult_a, mult_b;
    logic             mult_rdy;
    logic [15:0]      mult_result;

    mult_share_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req(req), .op_a(op_a), .op_b(op_b),
        .gnt(gnt), .done(done), .err(err), .result(result),
        .mult_ld(mult_ld), .mult_a(mult_a), .mult_b(mult_b),
        .mult_rdy(mult_rdy), .mult_result(mult_result)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] idx;
        logic [7:0] a;
        logic [7:0] b;
    } sb_t;

    int unsigned     n_checks = 0;
    int unsigned     n_fail   = 0;
    int unsigned     cyc      = 0;
    int unsigned     mult_lat = 4;      // 0: multiplier never answers
    logic            force_rdy = 1'b0;
    logic [7:0]      want_a [N];
    logic [7:0]      want_b [N];
    logic [7:0]      cur_a  [N];
    logic [7:0]      cur_b  [N];
    logic [N-1:0]    want = '0, drop = '0, busy = '0, auto_en = '0;
    sb_t             sb[$];
    int unsigned     gnt_log[$];
    int unsigned     n_ld = 0, n_done = 0, n_err = 0;

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned rr_pick(input logic [N-1:0] r, input int unsigned last);
        for (int unsigned k = 1; k <= N; k++) begin
            if (r[(last + k) % N]) return (last + k) % N;
        end
        return N;
    endfunction

    function automatic int unsigned idx_of(input logic [N-1:0] v);
        for (int unsigned k = 0; k < N; k++) if (v[k]) return k;
        return N;
    endfunction

    // Requester model: sole driver of req/op_a/op_b.
    initial begin : driver
        logic [7:0] a, b;
        req = '0; op_a = '0; op_b = '0;
        forever begin
            @(posedge clk); #1;
            if (!reset) begin
                req = '0; busy = '0; drop = '0; want = '0;
                sb.delete();
            end else begin
                for (int unsigned i = 0; i < N; i++) begin
                    if (drop[i]) begin
                        req[i]  = 1'b0;
                        drop[i] = 1'b0;
                    end else if (!busy[i] && (want[i] || auto_en[i])) begin
                        a = want[i] ? want_a[i] : 8'($urandom);
                        b = want[i] ? want_b[i] : 8'($urandom);
                        op_a[8*i +: 8] = a;
                        op_b[8*i +: 8] = b;
                        cur_a[i] = a;
                        cur_b[i] = b;
                        sb.push_back('{idx: 8'(i), a: a, b: b});
                        req[i]  = 1'b1;
                        busy[i] = 1'b1;
                        want[i] = 1'b0;
                    end
                end
            end
        end
    end

    // Multiplier model: answers mult_lat cycles after the load strobe.
    initial begin : mult_model
        int unsigned cd;
        logic        pend;
        logic [7:0]  pa, pb;
        mult_rdy = 1'b0; mult_result = '0; pend = 1'b0; cd = 0; pa = '0; pb = '0;
        forever begin
            @(negedge clk);
            if (!reset) pend = 1'b0;
            else if (mult_ld && mult_lat != 0) begin
                pend = 1'b1; cd = mult_lat; pa = mult_a; pb = mult_b;
            end
            @(posedge clk); #1;
            mult_rdy    = force_rdy;
            mult_result = 16'($urandom);
            if (pend && reset) begin
                if (cd == 1) begin
                    mult_rdy    = 1'b1;
                    mult_result = 16'(pa) * 16'(pb);
                    pend        = 1'b0;
                end else cd--;
            end
        end
    end

    initial begin : monitor
        logic [N-1:0] prev_gnt, prev_req, prev_done;
        logic         prev_ld, new_grant, timed_out;
        logic [15:0]  exp_hold, exp_res;
        int unsigned  last, ld_cyc, ld_lat, ei, i;
        int           fj;
        sb_t          e;
        prev_gnt = '0; prev_req = '0; prev_done = '0; prev_ld = 1'b0;
        exp_hold = '0; last = N - 1; ld_cyc = 0; ld_lat = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                check_eq("rst_gnt", gnt, 0);
                check_eq("rst_done", done, 0);
                check_eq("rst_err", err, 0);
                check_eq("rst_ld", mult_ld, 0);
                check_eq("rst_result", result, 0);
                check_eq("rst_mult_ab", {mult_a, mult_b}, 0);
                last = N - 1; exp_hold = '0;
                prev_gnt = '0; prev_req = '0; prev_done = '0; prev_ld = 1'b0;
            end else begin
                check_eq("gnt_onehot", $onehot0(gnt), 1);
                if (prev_done != 0) check_eq("gnt_clear_after_done", gnt, 0);
                new_grant = (gnt != 0) && (prev_gnt == 0);
                check_eq("ld_timing", mult_ld, new_grant);
                if (new_grant) begin
                    ei = rr_pick(prev_req, last);
                    check_eq("rr_grant", gnt, (ei < N) ? (32'd1 << ei) : 32'd0);
                    last = idx_of(gnt);
                    gnt_log.push_back(last);
                end else if (gnt != 0) begin
                    check_eq("gnt_held", gnt, prev_gnt);
                end
                if (mult_ld) begin
                    n_ld++;
                    i = idx_of(gnt);
                    if (i < N) begin
                        check_eq("mult_a", mult_a, cur_a[i]);
                        check_eq("mult_b", mult_b, cur_b[i]);
                    end
                    ld_cyc = cyc;
                    ld_lat = mult_lat;
                end
                if (done != 0) begin
                    n_done++;
                    if (err) n_err++;
                    check_eq("done_eq_gnt", done, gnt);
                    i  = idx_of(done);
                    fj = -1;
                    for (int j = 0; j < sb.size(); j++) begin
                        if (sb[j].idx == 8'(i)) begin fj = j; break; end
                    end
                    check_eq("done_expected", fj >= 0, 1);
                    if (fj >= 0) begin
                        e = sb[fj];
                        sb.delete(fj);
                        timed_out = (ld_lat == 0) || (ld_lat > TO);
                        exp_res   = timed_out ? 16'h0000 : 16'(e.a) * 16'(e.b);
                        check_eq("result", result, exp_res);
                        check_eq("err", err, timed_out);
                        check_eq("latency", cyc - ld_cyc, (timed_out ? TO : ld_lat) + 1);
                        exp_hold = exp_res;
                    end
                    if (i < N) begin drop[i] = 1'b1; busy[i] = 1'b0; end
                end else begin
                    check_eq("err_without_done", err, 0);
                    check_eq("result_hold", result, exp_hold);
                end
                prev_gnt = gnt; prev_req = req; prev_done = done; prev_ld = mult_ld;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #3 reset = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk);
    endtask

    task automatic drain(input string name, input int unsigned budget);
        int unsigned n = 0;
        while (!(sb.size() == 0 && busy == 0 && want == 0 && drop == 0) && n < budget) begin
            @(posedge clk); n++;
        end
        check_eq(name, n < budget, 1);
        repeat (3) @(posedge clk);
    endtask

    task automatic wait_grants(input string name, input int unsigned cnt, input int unsigned budget);
        int unsigned n = 0;
        while (gnt_log.size() < cnt && n < budget) begin @(posedge clk); n++; end
        check_eq(name, n < budget, 1);
    endtask

    initial begin : main
        int unsigned e0, d0, l0;
        logic [7:0]  ta, tb;
        reset = 1'b1;
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk);

        // Single request, multiplier latency 8
        gnt_log.delete(); l0 = n_ld; mult_lat = 8;
        want_a[0] = 8'd200; want_b[0] = 8'd128; want[0] = 1'b1;
        drain("drain_single", 200);
        check_eq("single_grants", gnt_log.size(), 1);
        check_eq("single_gnt0", (gnt_log.size() > 0) ? gnt_log[0] : 99, 0);
        check_eq("single_ld_count", n_ld - l0, 1);
        check_eq("single_result", result, 16'd25600);

        // All four from reset
        do_reset();
        gnt_log.delete(); mult_lat = 3;
        for (int unsigned i = 0; i < N; i++) begin
            want_a[i] = 8'((i + 1) * 10); want_b[i] = 8'd3;
        end
        want = '1;
        drain("drain_all4", 400);
        for (int unsigned k = 0; k < N; k++)
            check_eq("all4_order", (gnt_log.size() > k) ? gnt_log[k] : 99, k);
        check_eq("all4_last_result", result, 16'd120);

        // Requesters 1 and 3 continuously re-requesting
        gnt_log.delete(); mult_lat = 2; auto_en = 4'b1010;
        wait_grants("wait_alt", 8, 400);
        auto_en = '0;
        drain("drain_alt", 200);
        for (int unsigned k = 0; k < 8; k++)
            check_eq("alt_order", (gnt_log.size() > k) ? gnt_log[k] : 99, (k % 2 == 0) ? 1 : 3);

        // Watchdog abort, then ready exactly at the timeout boundary, then normal
        e0 = n_err; mult_lat = 0;
        want_a[2] = 8'($urandom); want_b[2] = 8'($urandom); want[2] = 1'b1;
        drain("drain_timeout", 300);
        check_eq("timeout_err_count", n_err - e0, 1);
        check_eq("timeout_result", result, 0);
        mult_lat = TO; ta = 8'($urandom_range(1, 255)); tb = 8'($urandom_range(1, 255));
        want_a[1] = ta; want_b[1] = tb; want[1] = 1'b1;
        drain("drain_boundary", 300);
        check_eq("boundary_no_err", n_err - e0, 1);
        check_eq("boundary_result", result, 16'(ta) * 16'(tb));
        mult_lat = 5;
        want_a[3] = 8'($urandom); want_b[3] = 8'($urandom); want[3] = 1'b1;
        drain("drain_after_timeout", 200);

        // Randomized contention with varying multiplier latency
        gnt_log.delete(); auto_en = '1;
        while (gnt_log.size() < 40) begin
            mult_lat = $urandom_range(1, 20);
            repeat (10) @(posedge clk);
            if (cyc > 20000) break;
        end
        check_eq("random_progress", gnt_log.size() >= 40, 1);
        auto_en = '0;
        drain("drain_random", 400);
        repeat (5) begin
            mult_lat = $urandom_range(1, 12);
            for (int unsigned i = 0; i < N; i++) begin
                if ($urandom_range(0, 1) == 1) begin
                    want_a[i] = 8'($urandom); want_b[i] = 8'($urandom); want[i] = 1'b1;
                end
            end
            drain("drain_burst", 400);
        end

        // Reset during WAIT, stray ready pulses, then requesters 2 and 0 together
        mult_lat = 0; l0 = n_ld;
        want_a[1] = 8'd77; want_b[1] = 8'd9; want[1] = 1'b1;
        for (int unsigned n = 0; n < 20 && n_ld == l0; n++) @(posedge clk);
        check_eq("wait_ld_before_reset", n_ld - l0, 1);
        repeat (10) @(posedge clk);
        d0 = n_done;
        #3 reset = 1'b0;
        #1;
        check_eq("async_gnt", gnt, 0);
        check_eq("async_done", done, 0);
        check_eq("async_err", err, 0);
        check_eq("async_ld", mult_ld, 0);
        check_eq("async_mult_a", mult_a, 0);
        check_eq("async_mult_b", mult_b, 0);
        check_eq("async_result", result, 0);
        force_rdy = 1'b1;
        @(posedge clk); #3 reset = 1'b1;
        @(posedge clk); #3 force_rdy = 1'b0;
        repeat (5) @(posedge clk);
        check_eq("no_done_after_reset", n_done - d0, 0);
        gnt_log.delete(); mult_lat = 4;
        want_a[2] = 8'd12; want_b[2] = 8'd12; want_a[0] = 8'd5; want_b[0] = 8'd7;
        want[2] = 1'b1; want[0] = 1'b1;
        drain("drain_post_reset", 200);
        check_eq("post_reset_first", (gnt_log.size() > 0) ? gnt_log[0] : 99, 0);
        check_eq("post_reset_second", (gnt_log.size() > 1) ? gnt_log[1] : 99, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got %0d checks expected completion", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
